// File: rtl/icache_pkg.sv
// Shared types and field widths for the direct-mapped instruction cache.
package icache_pkg;

  localparam int unsigned TAG_W   = 3;
  localparam int unsigned INDEX_W = 3;
  localparam int unsigned WORD_W  = 2;
  localparam int unsigned BLOCK_W = 128;

  // Prefixed literals keep the state names clear of the MEM_READ port name.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_READ = 2'd1,
    ST_UPDATE   = 2'd2
  } icache_state_e;

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays: combinational read port, synchronous write port,
// valid bits cleared synchronously on reset.
module icache_line_store
  import icache_pkg::*;
#(
  parameter int unsigned NUM_LINES = 8,
  parameter int unsigned LINE_W    = BLOCK_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [INDEX_W-1:0] rd_index_i,
  output logic               rd_valid_o,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic [LINE_W-1:0]  rd_data_o,
  input  logic               wr_en_i,
  input  logic [INDEX_W-1:0] wr_index_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic [LINE_W-1:0]  wr_data_i
);

  logic               valid_q [NUM_LINES];
  logic [TAG_W-1:0]   tag_q   [NUM_LINES];
  logic [LINE_W-1:0]  data_q  [NUM_LINES];

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_LINES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (wr_en_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // Tag and data need no reset: they are only observed through a set valid bit.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && !rst_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache with a three-state fill FSM.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module instruction_cache
  import icache_pkg::*;
#(
  parameter int unsigned NUM_LINES      = 8,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  PC,
  output logic [31:0]  INSTRUCTION,
  output logic         BUSYWAIT,
  output logic         MEM_READ,
  output logic [5:0]   MEM_ADDRESS,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]  HIT_COUNT,
  output logic [15:0]  MISS_COUNT
`endif
);

  localparam int unsigned LINE_W = WORDS_PER_LINE * 32;

  icache_state_e      state_q, state_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [INDEX_W-1:0] index_q, index_d;
  logic [LINE_W-1:0]  block_q, block_d;

  logic [TAG_W-1:0]   pc_tag;
  logic [INDEX_W-1:0] pc_index;
  logic [WORD_W-1:0]  pc_word;
  logic               unused_pc;

  logic               line_valid;
  logic [TAG_W-1:0]   line_tag;
  logic [LINE_W-1:0]  line_data;
  logic [WORDS_PER_LINE-1:0][31:0] line_words;
  logic               hit;

  logic               busy;
  logic               mem_rd;
  logic               wr_en;
  logic [31:0]        instr;

  assign pc_tag    = PC[9:7];
  assign pc_index  = PC[6:4];
  assign pc_word   = PC[3:2];
  assign unused_pc = ^{PC[31:10], PC[1:0]};

  icache_line_store #(
    .NUM_LINES (NUM_LINES),
    .LINE_W    (LINE_W)
  ) u_line_store (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .rd_index_i (pc_index),
    .rd_valid_o (line_valid),
    .rd_tag_o   (line_tag),
    .rd_data_o  (line_data),
    .wr_en_i    (wr_en && !RESET),
    .wr_index_i (index_q),
    .wr_tag_i   (tag_q),
    .wr_data_i  (block_q)
  );

  assign line_words = line_data;
  assign hit        = line_valid && (line_tag == pc_tag);

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    index_d = index_q;
    block_d = block_q;
    busy    = 1'b0;
    mem_rd  = 1'b0;
    wr_en   = 1'b0;
    instr   = '0;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          instr = line_words[pc_word];
        end else begin
          busy    = 1'b1;
          state_d = ST_MEM_READ;
          tag_d   = pc_tag;
          index_d = pc_index;
        end
      end
      ST_MEM_READ: begin
        busy   = 1'b1;
        mem_rd = 1'b1;
        if (!MEM_BUSYWAIT) begin
          block_d = MEM_READDATA[LINE_W-1:0];
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      tag_q   <= '0;
      index_q <= '0;
      block_q <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      index_q <= index_d;
      block_q <= block_d;
    end
  end

  // Stall and memory request are held low while reset is asserted.
  assign BUSYWAIT    = busy && !RESET;
  assign MEM_READ    = mem_rd && !RESET;
  assign MEM_ADDRESS = {tag_q, index_q};
  assign INSTRUCTION = instr;

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == ST_IDLE) begin
      if (hit) begin
        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 16'd1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Directed scoreboard bench for instruction_cache with a variable-latency memory model.
module tb_instruction_cache;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;
`ifdef ICACHE_STATS_EN
  logic [15:0]  HIT_COUNT;
  logic [15:0]  MISS_COUNT;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned mem_lat = 3;
  int unsigned mem_cnt = 0;

  typedef struct {
    logic [31:0] instr;
    int unsigned stall;
    int unsigned mr;
    logic [5:0]  addr;
  } exp_t;
  exp_t sb[$];

  logic       mv [8];
  logic [2:0] mt [8];

  instruction_cache #(.NUM_LINES(8), .WORDS_PER_LINE(4)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PC           (PC),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
    ,
    .HIT_COUNT    (HIT_COUNT),
    .MISS_COUNT   (MISS_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  // Word k of block a holds the byte address a*16 + 4k.
  function automatic logic [127:0] blk(input logic [5:0] a);
    logic [127:0] b;
    for (int k = 0; k < 4; k++) b[32*k +: 32] = {22'b0, a, k[1:0], 2'b00};
    return b;
  endfunction

  always @(posedge CLK) begin
    if (MEM_READ) mem_cnt <= mem_cnt + 1;
    else          mem_cnt <= 0;
  end

  assign MEM_BUSYWAIT = !(MEM_READ && (mem_cnt >= mem_lat - 1));
  assign MEM_READDATA = MEM_BUSYWAIT ? {4{32'hDEAD_BEEF}} : blk(MEM_ADDRESS);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) begin
      mv[i] = 1'b0;
      mt[i] = 3'd0;
    end
  endtask

  function automatic exp_t predict(input logic [31:0] pc);
    exp_t e;
    logic h;
    h = mv[pc[6:4]] && (mt[pc[6:4]] == pc[9:7]);
    e.instr = {22'b0, pc[9:2], 2'b00};
    e.stall = h ? 0 : mem_lat + 2;
    e.mr    = h ? 0 : mem_lat;
    e.addr  = h ? 6'h00 : pc[9:4];
    return e;
  endfunction

  task automatic compare(input string tag, input int unsigned stall, input int unsigned mr,
                         input logic [5:0] la, input logic nz);
    exp_t got;
    got = sb.pop_front();
    check({tag, ".instr"}, INSTRUCTION, got.instr);
    check({tag, ".stall"}, stall, got.stall);
    check({tag, ".memrd"}, mr, got.mr);
    check({tag, ".addr"}, {26'b0, la}, {26'b0, got.addr});
    check({tag, ".instr0"}, {31'b0, nz}, 32'd0);
  endtask

  // Called at posedge+1; returns at posedge+1 after the hit cycle.
  task automatic fetch(input logic [31:0] pc, input string tag);
    int unsigned stall = 0;
    int unsigned mr = 0;
    logic [5:0]  la = '0;
    logic        nz = 1'b0;
    sb.push_back(predict(pc));
    mv[pc[6:4]] = 1'b1;
    mt[pc[6:4]] = pc[9:7];
    PC = pc;
    forever begin
      @(negedge CLK);
      if (!BUSYWAIT || stall > 100) break;
      if (MEM_READ) begin
        mr++;
        la = MEM_ADDRESS;
      end
      if (INSTRUCTION !== 32'd0) nz = 1'b1;
      stall++;
    end
    compare(tag, stall, mr, la, nz);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int unsigned stall;
    int unsigned mr;
    logic [5:0]  la;
    logic        nz;
    logic        seen;

    clear_model();
    RESET = 1'b1;
    PC    = 32'd0;
    @(posedge CLK);
    @(negedge CLK);
    check("rst.busy", {31'b0, BUSYWAIT}, 32'd0);
    check("rst.memrd", {31'b0, MEM_READ}, 32'd0);
    check("rst.instr", INSTRUCTION, 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    fetch(32'h0, "cold");
    fetch(32'h4, "seq4");
    fetch(32'h8, "seq8");
    fetch(32'hC, "seq12");

    mem_lat = 1;
    fetch(32'h080, "evict80");
    mem_lat = 3;
    fetch(32'h000, "evict0");

    // PC moves to 0x20 during MEM_READ, back to 0x10 once UPDATE is seen.
    stall = 0; mr = 0; la = '0; nz = 1'b0; seen = 1'b0;
    sb.push_back(predict(32'h10));
    mv[1] = 1'b1;
    mt[1] = 3'd0;
    PC = 32'h10;
    forever begin
      @(negedge CLK);
      if (!BUSYWAIT || stall > 100) break;
      stall++;
      if (INSTRUCTION !== 32'd0) nz = 1'b1;
      @(posedge CLK);
      #1;
      if (MEM_READ) begin
        mr++;
        la = MEM_ADDRESS;
        seen = 1'b1;
        PC = 32'h20;
      end else if (seen) begin
        PC = 32'h10;
      end
    end
    compare("midfill", stall, mr, la, nz);
    @(posedge CLK);
    #1;
    fetch(32'h14, "midfill.hit");

    // Reset while MEM_READ is active aborts the fill of line 3.
    PC = 32'h30;
    @(negedge CLK);
    @(negedge CLK);
    check("rstfill.pre", {31'b0, MEM_READ}, 32'd1);
    RESET = 1'b1;
    #1;
    check("rstfill.memrd", {31'b0, MEM_READ}, 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    clear_model();
    fetch(32'h30, "rstfill.refetch");
    fetch(32'h34, "hit34");
    fetch(32'hABCD_7C3B, "highbits");
    fetch(32'h10, "afterrst.miss");

`ifdef ICACHE_STATS_EN
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    clear_model();
    fetch(32'h0, "st0");
    fetch(32'h4, "st4");
    fetch(32'h8, "st8");
    check("stats.hit3", {16'b0, HIT_COUNT}, 32'd3);
    check("stats.miss1", {16'b0, MISS_COUNT}, 32'd1);
    repeat (70000) @(posedge CLK);
    #1;
    check("stats.hitsat", {16'b0, HIT_COUNT}, 32'h0000_FFFF);
    check("stats.miss1b", {16'b0, MISS_COUNT}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
